// File: rtl/sad_block_feeder.sv
// sad_block_feeder: buffers one current block and one reference block of
// pixels from a byte stream. It pulses go to start the SAD engine, then serves
// the engine's pixel index i with the addressed pixel pair on A/B. It detects
// end of pass when the engine index reaches N_PIX.
module sad_block_feeder #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 256,
  parameter int IDX_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ld_cur,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] i,
  output logic [PIX_W-1:0] A,
  output logic [PIX_W-1:0] B,
  output logic             go,
  output logic             busy,
  output logic             done
);

  localparam int               AW       = $clog2(N_PIX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(N_PIX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CUR,
    S_LOAD_REF,
    S_GO,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] wcnt_q, wcnt_d;
  logic             cur_we, ref_we;
  logic [AW-1:0]    rd_addr;
  logic             rd_in_range;

  logic [PIX_W-1:0] cur_mem_q [N_PIX];
  logic [PIX_W-1:0] ref_mem_q [N_PIX];

  // Next-state, write-counter and memory write-enable logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cur_we  = 1'b0;
    ref_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wcnt_d  = '0;
          state_d = ld_cur ? S_LOAD_CUR : S_LOAD_REF;
        end
      end
      S_LOAD_CUR: begin
        if (in_valid) begin
          cur_we = 1'b1;
          if (wcnt_q == LAST_IDX) begin
            wcnt_d  = '0;
            state_d = S_LOAD_REF;
          end else begin
            wcnt_d = wcnt_q + IDX_W'(1);
          end
        end
      end
      S_LOAD_REF: begin
        if (in_valid) begin
          ref_we = 1'b1;
          if (wcnt_q == LAST_IDX) begin
            wcnt_d  = '0;
            state_d = S_GO;
          end else begin
            wcnt_d = wcnt_q + IDX_W'(1);
          end
        end
      end
      S_GO:    state_d = S_WAIT;
      S_WAIT:  if (i == END_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and write-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Pixel storage: write port addressed by wcnt, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the arrays are reset explicitly because an aborted or fresh pass
    // must read zeros. This makes them flops rather than RAM macros.
    if (rst) begin
      for (int k = 0; k < N_PIX; k++) begin
        cur_mem_q[k] <= '0;
        ref_mem_q[k] <= '0;
      end
    end else begin
      if (cur_we) cur_mem_q[wcnt_q[AW-1:0]] <= in_data;
      if (ref_we) ref_mem_q[wcnt_q[AW-1:0]] <= in_data;
    end
  end

  // Zero-latency read path; out-of-range indices (incl. the end marker) read 0.
  always_comb begin
    rd_addr     = i[AW-1:0];
    rd_in_range = (i < END_IDX);
    A           = rd_in_range ? cur_mem_q[rd_addr] : '0;
    B           = rd_in_range ? ref_mem_q[rd_addr] : '0;
  end

  // Handshake and status outputs decoded from the registered state only.
  always_comb begin
    in_ready = (state_q == S_LOAD_CUR) || (state_q == S_LOAD_REF);
    go       = (state_q == S_GO);
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_sad_block_feeder.sv
// Testbench for sad_block_feeder: reset, full/stalled/ref-only/random passes
// against a block-level model, boundary reads, abort by reset, start in WAIT.
module tb_sad_block_feeder;

  localparam int PIX_W = 8;
  localparam int N_PIX = 256;
  localparam int IDX_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             ld_cur = 1'b0;
  logic [PIX_W-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IDX_W-1:0] i = '0;
  logic [PIX_W-1:0] A, B;
  logic             go, busy, done;

  sad_block_feeder #(.PIX_W(PIX_W), .N_PIX(N_PIX), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_cur(ld_cur),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .i(i), .A(A), .B(B), .go(go), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Block-level reference model: what each block should contain.
  logic [PIX_W-1:0] m_cur [N_PIX];
  logic [PIX_W-1:0] m_ref [N_PIX];

  typedef struct {
    int               idx;
    logic [PIX_W-1:0] exp_a;
    logic [PIX_W-1:0] exp_b;
  } rd_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_sad();
    int s = 0;
    for (int k = 0; k < N_PIX; k++)
      s += (m_cur[k] > m_ref[k]) ? int'(m_cur[k]) - int'(m_ref[k])
                                 : int'(m_ref[k]) - int'(m_cur[k]);
    return s;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_PIX; k++) begin
      m_cur[k] = '0;
      m_ref[k] = '0;
    end
  endtask

  task automatic do_reset(input logic [IDX_W-1:0] idx);
    @(negedge clk);
    rst = 1'b1;
    i   = idx;
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic do_start(input logic lc);
    @(negedge clk);
    start  = 1'b1;
    ld_cur = lc;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Stream bytes at negedges; mode 0 = valid held high, 1 = toggle, 2 = random.
  task automatic stream(input logic [PIX_W-1:0] bytes[$], input int mode,
                        output int xfers, output int rdy_cycles);
    int idx = 0;
    int cyc = 0;
    xfers = 0;
    rdy_cycles = 0;
    while (idx < bytes.size() && cyc < 5000) begin
      if (in_ready) rdy_cycles++;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2) == 0;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? bytes[idx] : PIX_W'($urandom);
      if (in_valid && in_ready) begin
        idx++;
        xfers++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (cyc >= 5000) check("stream_timeout", 1, 0);
  endtask

  // Model SAD engine: starts at the go cycle, walks i, then waits for done.
  task automatic run_engine(input bit poke_start, output int sad);
    int extra_go = 0;
    int early_done = 0;
    sad = 0;
    i = '0;
    for (int k = 0; k < N_PIX; k++) begin
      @(negedge clk);
      sad += (A > B) ? int'(A) - int'(B) : int'(B) - int'(A);
      if (go) extra_go++;
      if (done) early_done++;
      if (poke_start && k == 100) begin
        start  = 1'b1;
        ld_cur = 1'b1;
      end
      if (poke_start && k == 101) begin
        start = 1'b0;
        check("wait_start_in_ready", in_ready, 0);
        check("wait_start_busy", busy, 1);
      end
      i = IDX_W'(k + 1);
    end
    start = 1'b0;
    check("go_single_pulse", extra_go, 0);
    check("done_not_early", early_done, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic readback(input string name);
    int errs = 0;
    for (int k = 0; k < N_PIX; k++) begin
      i = IDX_W'(k);
      #1;
      if (A !== m_cur[k] || B !== m_ref[k]) errs++;
    end
    check(name, errs, 0);
  endtask

  task automatic do_pass(input logic lc, input int mode, input logic [PIX_W-1:0] bytes[$],
                         input bit poke_start, input string tag);
    int xfers, rdy, sad;
    int n = lc ? 2 * N_PIX : N_PIX;
    do_start(lc);
    stream(bytes, mode, xfers, rdy);
    check({tag, "_xfers"}, xfers, n);
    if (mode == 0) check({tag, "_ready_cycles"}, rdy, n);
    check({tag, "_go_after_last"}, go, 1);
    check({tag, "_ready_low_in_go"}, in_ready, 0);
    for (int k = 0; k < N_PIX; k++) begin
      if (lc) begin
        m_cur[k] = bytes[k];
        m_ref[k] = bytes[N_PIX + k];
      end else begin
        m_ref[k] = bytes[k];
      end
    end
    run_engine(poke_start, sad);
    check({tag, "_sad"}, sad, model_sad());
    readback({tag, "_readback"});
  endtask

  initial begin
    rd_vec_t          vecs [7];
    logic [PIX_W-1:0] q[$];
    int               xfers, rdy, go_seen, sad;

    vecs[0] = '{0,   8'd0,   8'd255};
    vecs[1] = '{1,   8'd1,   8'd254};
    vecs[2] = '{128, 8'd128, 8'd127};
    vecs[3] = '{255, 8'd255, 8'd0};
    vecs[4] = '{256, 8'd0,   8'd0};
    vecs[5] = '{300, 8'd0,   8'd0};
    vecs[6] = '{511, 8'd0,   8'd0};

    do_reset(IDX_W'(5));

    // Full pass: cur = k, ref = 255-k.
    q = {};
    for (int k = 0; k < N_PIX; k++) q.push_back(PIX_W'(k));
    for (int k = 0; k < N_PIX; k++) q.push_back(PIX_W'(255 - k));
    do_pass(1'b1, 0, q, 1'b0, "full");
    check("full_sad_const", model_sad(), 32768);

    // Boundary reads against the first-pass contents.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      i = IDX_W'(vecs[v].idx);
      #1;
      check($sformatf("rd_A_i%0d", vecs[v].idx), A, vecs[v].exp_a);
      check($sformatf("rd_B_i%0d", vecs[v].idx), B, vecs[v].exp_b);
    end

    // Stalled load, same data, start poked during WAIT.
    do_pass(1'b1, 1, q, 1'b1, "stall");

    // Ref-only reload with ref == cur: cur kept, SAD 0.
    q = {};
    for (int k = 0; k < N_PIX; k++) q.push_back(PIX_W'(k));
    do_pass(1'b0, 0, q, 1'b0, "refonly");
    check("refonly_sad_zero", model_sad(), 0);

    // Randomized full pass, then randomized ref-only pass.
    q = {};
    for (int k = 0; k < 2 * N_PIX; k++) q.push_back(PIX_W'($urandom));
    do_pass(1'b1, 2, q, 1'b0, "rnd_full");
    q = {};
    for (int k = 0; k < N_PIX; k++) q.push_back(PIX_W'($urandom));
    do_pass(1'b0, 2, q, 1'b0, "rnd_ref");

    // Abort: reset after 100 ref bytes.
    q = {};
    for (int k = 0; k < 100; k++) q.push_back(PIX_W'($urandom_range(1, 255)));
    do_start(1'b0);
    stream(q, 0, xfers, rdy);
    check("abort_xfers", xfers, 100);
    check("abort_still_loading", in_ready, 1);
    do_reset(IDX_W'(3));
    #1;
    check("abort_A_i3", A, 0);
    check("abort_B_i3", B, 0);
    go_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (go || busy) go_seen++;
    end
    check("abort_no_go", go_seen, 0);

    // Ref-only after reset reuses zeroed cur block.
    q = {};
    for (int k = 0; k < N_PIX; k++) q.push_back(PIX_W'($urandom));
    do_pass(1'b0, 2, q, 1'b0, "ref_after_rst");
    sad = 0;
    for (int k = 0; k < N_PIX; k++) sad += int'(q[k]);
    check("ref_after_rst_sum", model_sad(), sad);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sad_block_feeder.md
# sad_block_feeder

Pixel-side responder for the SAD engine. Buffers one 256-pixel current block and one 256-pixel reference block from a byte stream, issues the single-cycle `go` that starts the SAD engine, then answers its pixel index `i` with the addressed pair on `A`/`B`. Tracks the engine's index to detect end of pass. For full search, the current block can be kept and only the reference block reloaded for each candidate position.

## Interface
- `PIX_W`, default 8: pixel width in bits.
- `N_PIX`, default 256: pixels per block.
- `IDX_W`, default 9: width of the engine index. It must hold the value `N_PIX`.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin a load/compute pass; sampled in IDLE only.
- `ld_cur`  in  1: sampled with `start`.
  - 1: reload the current block, then the reference block.
  - 0: reload the reference block only.
- `in_data`  in  PIX_W: stream byte.
- `in_valid`  in  1: `in_data` valid.
- `in_ready`  out  1: feeder accepts a byte this cycle.
- `i`  in  IDX_W: pixel index from the SAD engine.
- `A`  out  PIX_W: current-block pixel at `i`.
- `B`  out  PIX_W: reference-block pixel at `i`.
- `go`  out  1: one-cycle start pulse to the SAD engine.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the engine's pass ends.

## Operation
- Storage: two arrays, `cur_mem` and `ref_mem`, each `N_PIX` x `PIX_W`. A 9-bit write counter `wcnt` addresses whichever array is being loaded.
- States: IDLE, LOAD_CUR, LOAD_REF, GO, WAIT, DONE.
- IDLE:
  - `start`=1 and `ld_cur`=1 -> LOAD_CUR.
  - `start`=1 and `ld_cur`=0 -> LOAD_REF.
  - `wcnt` cleared on entry to either load state.
- LOAD_CUR / LOAD_REF:
  - `in_ready`=1.
  - A transfer is `in_valid && in_ready`. It writes `in_data` to `mem[wcnt]` and increments `wcnt`.
  - A transfer with `wcnt`=N_PIX-1 completes the block.
    - LOAD_CUR -> LOAD_REF, with `wcnt` set to 0.
    - LOAD_REF -> GO.
  - `in_valid`=0 stalls the load indefinitely; no state change.
- GO: `go`=1 for exactly this cycle, then -> WAIT.
- WAIT: when `i`==N_PIX -> DONE. All other `i` values are served normally.
- DONE: `done`=1 for one cycle, then -> IDLE.
- Read path:
  - Combinational, in every state: `A`=`cur_mem[i]`, `B`=`ref_mem[i]` for `i`<N_PIX.
  - For `i`>=N_PIX, `A`=`B`=0.
- `start` outside IDLE is ignored, with no queuing.
- Stream bytes presented while `in_ready`=0 are not consumed.
- The `ld_cur`=0 pass reuses the `cur_mem` contents from the last completed load, or zeros after reset.

## Timing
- Reset values (async):
  - state=IDLE, `wcnt`=0.
  - `in_ready`=0, `go`=0, `busy`=0, `done`=0.
  - All `cur_mem`/`ref_mem` entries are 0, so `A`=`B`=0.
- `go`, `done`, `busy` and `in_ready` are decoded from the registered state and are glitch-free relative to `clk`.
- Load latency with `in_valid` held high: 256 cycles for a ref-only pass, 512 cycles for a full pass. GO follows the last transfer on the next cycle.
- A byte written at edge k is visible on `A`/`B` from edge k onward.
- The engine needs `A`/`B` in the same cycle it presents `i`, so the read path is zero-latency (no pipeline register).
- `done` asserts one cycle after the first cycle `i`==N_PIX is seen in WAIT.
- `rst` mid-load or mid-WAIT:
  - Immediate return to IDLE and memories cleared.
  - A partial block is never retained.
  - A `go` that was already issued is not re-issued.
- `start` in the same cycle as the DONE->IDLE transition is ignored; it must be presented while in IDLE.

## Test plan
- Reset check: assert `rst` with `i`=5. All outputs are 0, including `A`=`B`=0.
- Full pass:
  - Stimulus: `start`,`ld_cur`=1; stream cur bytes k, then ref bytes 255-k, `in_valid` held high.
  - `in_ready` is high for exactly 512 cycles.
  - `go` pulses exactly once, on the cycle after the last transfer.
  - With a model SAD engine attached, `done` pulses after `i` reaches 256, and the engine reports sad_reg = 32768.
- Stalled load: toggle `in_valid` every other cycle. Exactly 512 bytes are written, in order, and the same SAD results.
- Ref-only reload:
  - Stimulus: after the full pass, `start`,`ld_cur`=0 with ref bytes equal to the cur bytes.
  - Only 256 transfers occur.
  - `cur_mem` is unchanged, and the engine SAD = 0.
- Boundary read: drive `i`=255 -> `A`=255, `B`=0 (first pass data); drive `i`=256 -> `A`=`B`=0.
- Abort and ignore:
  - Assert `rst` after 100 ref bytes: the feeder returns to IDLE, no `go` pulse, `A` reads 0 at `i`=3.
  - Assert `start` during WAIT: no effect on state or `in_ready`.
